id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Registered instruction-decode stage of the RV32I core.
- Accepts fetched instruction/PC pairs over a valid/ready handshake and decodes them into the operand-select, ALU-control, branch-control and immediate signals consumed by the execute stage.
- Holds one decoded instruction in an output pipeline register, with stall and flush support.
- A taken branch or jump in execute flushes the held instruction.

Parameters:
- WIDTH, 32, datapath width of pc and imm outputs.
- RESET_PC, 32'h0000_0000, value the held pc output takes on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_instr  input  32  raw instruction word.
- in_pc  input  WIDTH  PC of in_instr.
- flush  input  1  execute redirect (pcbranch or jump taken); discards the held and incoming instruction.
- out_valid  output  1  decoded instruction held for execute.
- out_ready  input  1  execute consumes the held instruction.
- pc  output  WIDTH  PC of the held instruction.
- imm  output  WIDTH  sign/format-extended immediate.
- ALUa  output  2  operand A select: 01 zero, 10 pc, 11 Rd1.
- ALUb  output  2  operand B select: 00 Rd2, 01 Rd2&0x1F, 10 imm, 11 constant 4.
- alu_cntr  output  4  0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
- branch_cntr  output  3  000 none, 001 beq, 010 bne, 011 blt/bltu, 100 bge/bgeu.
- rs1, rs2, rd  output  5 each  register addresses.
- reg_we  output  1  write rd.
- mem_rd, mem_wr  output  1 each  load / store.
- mem_funct3  output  3  load/store size and sign (instr[14:12]).
- jal, jalr  output  1 each  unconditional jump kinds.
- illegal  output  1  held instruction is not a legal RV32I encoding.

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, pc=RESET_PC.
  - All decoded outputs 0, except ALUa=11 and ALUb=00 (NOP-equivalent).
  - Reset mid-transfer drops the held instruction.
- Handshake and latency:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready & !flush.
  - On accept, the decoded fields are registered and out_valid=1 on the next edge; latency is 1 cycle.
  - If out_valid & out_ready and no accept, out_valid clears.
  - If out_valid & !out_ready, all outputs hold stable.
- Flush:
  - flush=1 clears out_valid on the next edge and blocks acceptance that cycle, even if in_valid & in_ready.
  - Flush has priority over accept and over hold.
- Decoding is by opcode in_instr[6:0]:
  - LUI 0110111: ALUa=01, ALUb=10, ADD, reg_we; imm = U-type {instr[31:12],12'b0}.
  - AUIPC 0010111: ALUa=10, ALUb=10, ADD, reg_we; imm U-type.
  - JAL 1101111: ALUa=10, ALUb=11, ADD, reg_we, jal; imm J-type sign-extended.
  - JALR 1100111 (funct3=000): ALUa=10, ALUb=11, ADD, reg_we, jalr; imm I-type.
  - BRANCH 1100011: ALUa=11, ALUb=00, B-type imm.
    - beq/bne use SUB with branch_cntr 001/010.
    - blt/bge use SLT and bltu/bgeu use SLTU, with branch_cntr 011/100.
    - funct3 010/011 is illegal.
  - LOAD 0000011: ALUa=11, ALUb=10, ADD, mem_rd, reg_we; I-type imm; funct3 in {000,001,010,100,101}, else illegal.
  - STORE 0100011: ALUa=11, ALUb=10, ADD, mem_wr; S-type imm; funct3 in {000,001,010}, else illegal.
  - OP-IMM 0010011: ALUa=11, ALUb=10, reg_we; I-type imm.
    - SLLI/SRLI/SRAI use imm={27'b0,instr[24:20]}.
    - SRAI requires instr[30]=1; slli/srli require instr[31:25]=0, else illegal.
  - OP 0110011: ALUa=11, reg_we.
    - ALUb=01 for SLL/SRL/SRA, else 00.
    - funct7 must be 0000000, or 0100000 for SUB/SRA only, else illegal.
- Any other opcode, or instr[1:0]!=11, sets illegal=1.
  - All side-effect outputs (reg_we, mem_rd, mem_wr, jal, jalr, branch_cntr) are forced 0.
  - The entry still passes through the handshake.
- rs1=instr[19:15], rs2=instr[24:20] and rd=instr[11:7] are always registered.
  - reg_we is forced 0 when rd=0.
- imm sign bit is always instr[31], except for shift immediates.

Test Plan:
- Reset then in_instr=32'h00500093 (addi x1,x0,5), in_pc=0x100 -> next cycle out_valid=1, pc=0x100, ALUa=11, ALUb=10, alu_cntr=0000, imm=5, rd=1, reg_we=1.
- in_instr=32'hFE208EE3 (beq x1,x2,-4) -> imm=0xFFFFFFFC, alu_cntr=0001, branch_cntr=001, reg_we=0.
- in_instr=32'h008000EF (jal x1,8), pc=0x200 -> ALUa=10, ALUb=11, imm=8, jal=1, reg_we=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; raise out_ready -> next instruction loads in the same cycle, out_valid stays 1.
- Assert flush with in_valid=1, in_ready=1 -> out_valid=0 next cycle, incoming instruction not captured.
- in_instr=32'hFFFFFFFF -> illegal=1, reg_we=0, mem_wr=0, branch_cntr=000; rst_n low mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: registered RV32I decode stage.
// Takes instruction/PC pairs over a valid/ready handshake and holds one decoded
// entry for execute. A flush from execute discards the held and incoming entry.
module id_stage #(
    parameter int unsigned           WIDTH    = 32,
    parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] imm,
    output logic [1:0]       ALUa,
    output logic [1:0]       ALUb,
    output logic [3:0]       alu_cntr,
    output logic [2:0]       branch_cntr,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [2:0]       mem_funct3,
    output logic             jal,
    output logic             jalr,
    output logic             illegal
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_EQ   = 3'b001,
        BR_NE   = 3'b010,
        BR_LT   = 3'b011,
        BR_GE   = 3'b100
    } br_op_e;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        accept;

    logic        illegal_d;
    logic [1:0]  alua_d;
    logic [1:0]  alub_d;
    alu_op_e     alu_d;
    br_op_e      br_d;
    logic        we_d;
    logic        mrd_d;
    logic        mwr_d;
    logic        jal_d;
    logic        jalr_d;
    logic [31:0] imm32;

    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Combinational decode of the incoming instruction word.
    always_comb begin
        illegal_d = 1'b0;
        alua_d    = 2'b11;
        alub_d    = 2'b00;
        alu_d     = ALU_ADD;
        br_d      = BR_NONE;
        we_d      = 1'b0;
        mrd_d     = 1'b0;
        mwr_d     = 1'b0;
        jal_d     = 1'b0;
        jalr_d    = 1'b0;
        imm32     = {{20{in_instr[31]}}, in_instr[31:20]};

        case (in_instr[6:0])
            OPC_LUI: begin
                alua_d = 2'b01;
                alub_d = 2'b10;
                we_d   = 1'b1;
                imm32  = {in_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                alua_d = 2'b10;
                alub_d = 2'b10;
                we_d   = 1'b1;
                imm32  = {in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                alua_d = 2'b10;
                alub_d = 2'b11;
                we_d   = 1'b1;
                jal_d  = 1'b1;
                imm32  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                alua_d    = 2'b10;
                alub_d    = 2'b11;
                we_d      = 1'b1;
                jalr_d    = 1'b1;
                illegal_d = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0};
                case (funct3)
                    3'b000: begin alu_d = ALU_SUB;  br_d = BR_EQ; end
                    3'b001: begin alu_d = ALU_SUB;  br_d = BR_NE; end
                    3'b100: begin alu_d = ALU_SLT;  br_d = BR_LT; end
                    3'b101: begin alu_d = ALU_SLT;  br_d = BR_GE; end
                    3'b110: begin alu_d = ALU_SLTU; br_d = BR_LT; end
                    3'b111: begin alu_d = ALU_SLTU; br_d = BR_GE; end
                    default: illegal_d = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                alub_d    = 2'b10;
                mrd_d     = 1'b1;
                we_d      = 1'b1;
                illegal_d = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                            (funct3 == 3'b111);
            end
            OPC_STORE: begin
                alub_d    = 2'b10;
                mwr_d     = 1'b1;
                imm32     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                illegal_d = (funct3[2] || funct3 == 3'b011);
            end
            OPC_OPIMM: begin
                alub_d = 2'b10;
                we_d   = 1'b1;
                case (funct3)
                    3'b000: alu_d = ALU_ADD;
                    3'b010: alu_d = ALU_SLT;
                    3'b011: alu_d = ALU_SLTU;
                    3'b100: alu_d = ALU_XOR;
                    3'b110: alu_d = ALU_OR;
                    3'b111: alu_d = ALU_AND;
                    3'b001: begin
                        alu_d     = ALU_SLL;
                        imm32     = {27'b0, in_instr[24:20]};
                        illegal_d = (funct7 != 7'b0000000);
                    end
                    default: begin
                        imm32 = {27'b0, in_instr[24:20]};
                        if (funct7 == 7'b0000000)
                            alu_d = ALU_SRL;
                        else if (funct7 == 7'b0100000)
                            alu_d = ALU_SRA;
                        else
                            illegal_d = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                we_d   = 1'b1;
                alub_d = (funct3 == 3'b001 || funct3 == 3'b101) ? 2'b01 : 2'b00;
                case (funct3)
                    3'b000:  alu_d = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_d = ALU_SLL;
                    3'b010:  alu_d = ALU_SLT;
                    3'b011:  alu_d = ALU_SLTU;
                    3'b100:  alu_d = ALU_XOR;
                    3'b101:  alu_d = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_d = ALU_OR;
                    default: alu_d = ALU_AND;
                endcase
                if (funct7 == 7'b0100000)
                    illegal_d = !(funct3 == 3'b000 || funct3 == 3'b101);
                else
                    illegal_d = (funct7 != 7'b0000000);
            end
            default: illegal_d = 1'b1;
        endcase

        // Illegal entries must not cause any architectural side effect.
        if (illegal_d) begin
            we_d   = 1'b0;
            mrd_d  = 1'b0;
            mwr_d  = 1'b0;
            jal_d  = 1'b0;
            jalr_d = 1'b0;
            br_d   = BR_NONE;
        end
        if (in_instr[11:7] == 5'd0)
            we_d = 1'b0;
    end

    // Output pipeline register: flush beats accept beats drain; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            pc          <= RESET_PC;
            imm         <= '0;
            ALUa        <= 2'b11;
            ALUb        <= 2'b00;
            alu_cntr    <= '0;
            branch_cntr <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            reg_we      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_funct3  <= '0;
            jal         <= 1'b0;
            jalr        <= 1'b0;
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            pc          <= in_pc;
            imm         <= WIDTH'($signed(imm32));
            ALUa        <= alua_d;
            ALUb        <= alub_d;
            alu_cntr    <= alu_d;
            branch_cntr <= br_d;
            rs1         <= in_instr[19:15];
            rs2         <= in_instr[24:20];
            rd          <= in_instr[11:7];
            reg_we      <= we_d;
            mem_rd      <= mrd_d;
            mem_wr      <= mwr_d;
            mem_funct3  <= funct3;
            jal         <= jal_d;
            jalr        <= jalr_d;
            illegal     <= illegal_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage with hand-computed expectations.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [1:0]  ALUa;
    logic [1:0]  ALUb;
    logic [3:0]  alu_cntr;
    logic [2:0]  branch_cntr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_funct3;
    logic        jal;
    logic        jalr;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    id_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc(pc), .imm(imm), .ALUa(ALUa), .ALUb(ALUb),
        .alu_cntr(alu_cntr), .branch_cntr(branch_cntr),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_funct3(mem_funct3), .jal(jal), .jalr(jalr), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] p);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = p;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst pc",        pc,             32'h0);
        check("rst ALUa",      32'(ALUa),      3);
        check("rst ALUb",      32'(ALUb),      0);
        check("rst imm",       imm,            0);
        check("rst reg_we",    32'(reg_we),    0);
        check("rst in_ready",  32'(in_ready),  1);
        rst_n = 1'b1;
        tick();

        // addi x1,x0,5
        drive(32'h00500093, 32'h100);
        tick();
        check("addi out_valid", 32'(out_valid), 1);
        check("addi pc",        pc,             32'h100);
        check("addi ALUa",      32'(ALUa),      3);
        check("addi ALUb",      32'(ALUb),      2);
        check("addi alu",       32'(alu_cntr),  0);
        check("addi imm",       imm,            5);
        check("addi rd",        32'(rd),        1);
        check("addi reg_we",    32'(reg_we),    1);

        // beq x1,x2,-4
        drive(32'hFE208EE3, 32'h104);
        tick();
        check("beq imm",    imm,               32'hFFFF_FFFC);
        check("beq alu",    32'(alu_cntr),     1);
        check("beq br",     32'(branch_cntr),  1);
        check("beq reg_we", 32'(reg_we),       0);
        check("beq ALUb",   32'(ALUb),         0);
        check("beq rs1",    32'(rs1),          1);
        check("beq rs2",    32'(rs2),          2);

        // jal x1,8
        drive(32'h008000EF, 32'h200);
        tick();
        check("jal ALUa",   32'(ALUa),   2);
        check("jal ALUb",   32'(ALUb),   3);
        check("jal imm",    imm,         8);
        check("jal jal",    32'(jal),    1);
        check("jal reg_we", 32'(reg_we), 1);
        check("jal pc",     pc,          32'h200);

        // Stall with lw x5,12(x2) waiting
        out_ready = 1'b0;
        drive(32'h00C12283, 32'h204);
        #1;
        check("stall in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall out_valid", 32'(out_valid), 1);
            check("stall pc",        pc,             32'h200);
            check("stall jal",       32'(jal),       1);
            check("stall in_ready",  32'(in_ready),  0);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 1);
        tick();
        check("lw out_valid", 32'(out_valid),  1);
        check("lw pc",        pc,              32'h204);
        check("lw mem_rd",    32'(mem_rd),     1);
        check("lw imm",       imm,             12);
        check("lw rd",        32'(rd),         5);
        check("lw funct3",    32'(mem_funct3), 2);
        check("lw jal",       32'(jal),        0);

        // Flush blocks acceptance of sub x3,x1,x2
        drive(32'h402081B3, 32'h300);
        flush = 1'b1;
        tick();
        check("flush out_valid", 32'(out_valid), 0);
        check("flush pc",        pc,             32'h204);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("idle out_valid", 32'(out_valid), 0);

        drive(32'h402081B3, 32'h300);
        tick();
        check("sub alu",     32'(alu_cntr), 1);
        check("sub ALUb",    32'(ALUb),     0);
        check("sub rd",      32'(rd),       3);
        check("sub illegal", 32'(illegal),  0);

        // srai x4,x1,3
        drive(32'h4030D213, 32'h304);
        tick();
        check("srai alu",     32'(alu_cntr), 7);
        check("srai imm",     imm,           3);
        check("srai illegal", 32'(illegal),  0);

        // lui x5,0x12345
        drive(32'h123452B7, 32'h308);
        tick();
        check("lui ALUa", 32'(ALUa), 1);
        check("lui imm",  imm,       32'h1234_5000);

        // sw x2,8(x1)
        drive(32'h0020A423, 32'h30C);
        tick();
        check("sw mem_wr", 32'(mem_wr), 1);
        check("sw reg_we", 32'(reg_we), 0);
        check("sw imm",    imm,         8);

        // addi x0,x0,0: no write to x0
        drive(32'h00000013, 32'h310);
        tick();
        check("nop reg_we",  32'(reg_we),  0);
        check("nop illegal", 32'(illegal), 0);

        // branch funct3=010 is illegal
        drive(32'hFE20AEE3, 32'h314);
        tick();
        check("br010 illegal", 32'(illegal),     1);
        check("br010 br",      32'(branch_cntr), 0);

        // all-ones word
        drive(32'hFFFFFFFF, 32'h318);
        tick();
        check("ones out_valid", 32'(out_valid),   1);
        check("ones illegal",   32'(illegal),     1);
        check("ones reg_we",    32'(reg_we),      0);
        check("ones mem_wr",    32'(mem_wr),      0);
        check("ones br",        32'(branch_cntr), 0);

        // Reset during a stall drops the held entry at once
        out_ready = 1'b0;
        drive(32'h00500093, 32'h31C);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst out_valid", 32'(out_valid), 0);
        check("arst pc",        pc,             32'h0);
        check("arst ALUa",      32'(ALUa),      3);
        check("arst illegal",   32'(illegal),   0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
